// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store per handshake, response after LATENCY cycles.
// Optional build macro DMEM_ALIGN_CHECK_EN enables misalignment / illegal-funct3 fault reporting.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_stall
);

  localparam int         WORD_W = ADDR_W - 2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  generate
    if ((2 ** ADDR_W) != (4 * DEPTH)) begin : g_bad_addr_w
      $error("dmem_responder: 2**ADDR_W must equal 4*DEPTH");
    end
    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_data;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic [WORD_W-1:0] w_idx;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_err;
  logic [31:0]       w_rsp_data;
  logic              w_accept;
  logic              w_wr_en;

  // Held off during reset so an asserted req_valid cannot slip a store into the array.
  assign req_ready = !rst && (r_state == S_IDLE);
  assign mem_stall = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign w_idx     = req_addr[ADDR_W-1:2];
  assign w_word    = r_mem[w_idx];
  assign w_accept  = req_valid && req_ready;
  assign w_wr_en   = w_accept && req_we && !w_err;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_byte  = w_word[7:0];
    w_half  = req_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load  = w_word;
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    w_err   = 1'b0;
    case (req_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    if (req_we) begin
      case (req_funct3)
        3'b000: begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_load = {24'd0, w_byte};
        3'b001:  w_load = {{16{w_half[15]}}, w_half};
        3'b101:  w_load = {16'd0, w_half};
        default: w_load = w_word;
      endcase
    end
`ifdef DMEM_ALIGN_CHECK_EN
    case (req_funct3)
      3'b000, 3'b100: w_err = req_we && req_funct3[2];
      3'b001, 3'b101: w_err = req_addr[0] || (req_we && req_funct3[2]);
      3'b010:         w_err = (req_addr[1:0] != 2'd0);
      default:        w_err = 1'b1;
    endcase
`else
    w_err = 1'b0;
`endif
    w_rsp_data = (req_we || w_err) ? 32'd0 : w_load;
  end

  // NOTE: the array has no reset; clearing it would force flops instead of RAM and is not required.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_data      <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data <= w_rsp_data;
            r_err  <= w_err;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_data;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_data;
            r_rsp_err   <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A (LATENCY=2) for data paths, instance B (LATENCY=3)
// for back-pressure. Expected values are hand-computed from the little-endian byte layout.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'd0;

  logic        a_req_valid = 1'b0, a_rsp_ready = 1'b0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_stall;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid = 1'b0, b_rsp_ready = 1'b0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_stall;
  logic [31:0] b_rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .ADDR_W(8), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .mem_stall(a_mem_stall)
  );

  dmem_responder #(.DEPTH(64), .ADDR_W(8), .LATENCY(3)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .mem_stall(b_mem_stall)
  );

  // Called at the negedge after the acceptance edge; lat = edges from acceptance until rsp_valid seen.
  task automatic wait_a_valid(output int lat);
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    a_req_valid = 1'b1;
    guard = 0;
    while (!a_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    wait_a_valid(lat);
    rd = a_rsp_rdata;
    er = a_rsp_err;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  // Issues one request to instance B and leaves the response pending.
  task automatic b_issue(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wd, output int lat);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a_rsp_valid, a_rsp_err, a_mem_stall, a_rsp_rdata} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b e=%b st=%b d=%h, want all 0",
               a_rsp_valid, a_rsp_err, a_mem_stall, a_rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_req_ready, b_req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_ready: got a=%b b=%b, want 1 1", a_req_ready, b_req_ready);
    end
  endtask

  task automatic test_store_latency;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, rd, er, lat);
    n_vec++;
    if (lat !== 2 || rd !== 32'd0 || er !== 1'b0) begin
      n_err++;
      $display("FAIL sw_0x10: got lat=%0d d=%h e=%b, want lat=2 d=0 e=0", lat, rd, er);
    end
  endtask

  task automatic test_load_ext;
    logic [7:0]  addrs [8] = '{8'h13, 8'h13, 8'h12, 8'h10, 8'h10, 8'h10, 8'h11, 8'h10};
    logic [2:0]  f3s   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100, 3'b010};
    logic [31:0] exps  [8] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF,
                               32'hFFFFFFEF, 32'hFFFFBEEF, 32'h000000BE, 32'hDEADBEEF};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, f3s[i], addrs[i], 32'd0, rd, er, lat);
      n_vec++;
      if (rd !== exps[i] || er !== 1'b0 || lat !== 2) begin
        n_err++;
        $display("FAIL load_ext[%0d] f3=%b @%h: got d=%h e=%b lat=%0d, want d=%h e=0 lat=2",
                 i, f3s[i], addrs[i], rd, er, lat, exps[i]);
      end
    end
    do_req(1'b1, 3'b001, 8'h16, 32'hABCD1234, rd, er, lat);
    do_req(1'b0, 3'b001, 8'h16, 32'd0, rd, er, lat);
    n_vec++;
    if (rd !== 32'h00001234) begin
      n_err++;
      $display("FAIL sh_lh_0x16: got %h, want 00001234", rd);
    end
    do_req(1'b0, 3'b000, 8'h17, 32'd0, rd, er, lat);
    n_vec++;
    if (rd !== 32'h00000012) begin
      n_err++;
      $display("FAIL lb_0x17: got %h, want 00000012", rd);
    end
  endtask

  task automatic test_raw;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 3'b000, 8'h11, 32'hFFFFFF55, rd, er, lat);
    do_req(1'b0, 3'b010, 8'h10, 32'd0, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEAD55EF) begin
      n_err++;
      $display("FAIL sb_merge: got %h, want DEAD55EF", rd);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    b_issue(1'b1, 3'b010, 8'h20, 32'h0BADF00D, lat);
    n_vec++;
    if (lat !== 3 || b_rsp_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL b_sw_latency: got lat=%0d d=%h, want lat=3 d=0", lat, b_rsp_rdata);
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    b_issue(1'b0, 3'b010, 8'h20, 32'd0, lat);
    n_vec++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL b_lw_latency: got %0d, want 3", lat);
    end
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if ({b_rsp_valid, b_req_ready, b_mem_stall} !== 3'b101 || b_rsp_rdata !== 32'h0BADF00D) begin
        n_err++;
        $display("FAIL b_hold[%0d]: got v=%b rdy=%b st=%b d=%h, want v=1 rdy=0 st=1 d=0BADF00D",
                 c, b_rsp_valid, b_req_ready, b_mem_stall, b_rsp_rdata);
      end
      @(negedge clk);
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    n_vec++;
    if ({b_rsp_valid, b_req_ready, b_mem_stall} !== 3'b010 || b_rsp_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL b_retire: got v=%b rdy=%b st=%b d=%h, want v=0 rdy=1 st=0 d=0",
               b_rsp_valid, b_req_ready, b_mem_stall, b_rsp_rdata);
    end
  endtask

  task automatic test_align;
    logic [31:0] rd; logic er; int lat;
`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b1, 3'b010, 8'h12, 32'h12345678, rd, er, lat);
    n_vec++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
      n_err++;
      $display("FAIL sw_misaligned: got e=%b d=%h lat=%0d, want e=1 d=0 lat=2", er, rd, lat);
    end
    do_req(1'b0, 3'b010, 8'h10, 32'd0, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      n_err++;
      $display("FAIL store_suppressed: got d=%h e=%b, want DEAD55EF e=0", rd, er);
    end
    do_req(1'b0, 3'b001, 8'h11, 32'd0, rd, er, lat);
    n_vec++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_err++;
      $display("FAIL lh_misaligned: got e=%b d=%h, want e=1 d=0", er, rd);
    end
`else
    do_req(1'b0, 3'b010, 8'h12, 32'd0, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      n_err++;
      $display("FAIL lw_0x12_wordaddr: got d=%h e=%b, want DEAD55EF e=0", rd, er);
    end
    do_req(1'b0, 3'b001, 8'h11, 32'd0, rd, er, lat);
    n_vec++;
    if (rd !== 32'h000055EF || er !== 1'b0) begin
      n_err++;
      $display("FAIL lh_0x11_halfaddr: got d=%h e=%b, want 000055EF e=0", rd, er);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h10;
    a_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    wait_a_valid(lat);
    a_rsp_ready = 1'b1;
    req_funct3 = 3'b100;
    a_req_valid = 1'b1;
    n_vec++;
    if (a_req_ready !== 1'b0 || a_rsp_rdata !== 32'hDEAD55EF) begin
      n_err++;
      $display("FAIL b2b_resp: got rdy=%b d=%h, want rdy=0 d=DEAD55EF", a_req_ready, a_rsp_rdata);
    end
    @(negedge clk);
    a_rsp_ready = 1'b0;
    n_vec++;
    if ({a_rsp_valid, a_req_ready, a_mem_stall} !== 3'b010 || a_rsp_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL b2b_idle_gap: got v=%b rdy=%b st=%b d=%h, want v=0 rdy=1 st=0 d=0",
               a_rsp_valid, a_req_ready, a_mem_stall, a_rsp_rdata);
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    n_vec++;
    if ({a_req_ready, a_mem_stall} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_accept: got rdy=%b st=%b, want rdy=0 st=1", a_req_ready, a_mem_stall);
    end
    wait_a_valid(lat);
    n_vec++;
    if (lat !== 2 || a_rsp_rdata !== 32'h000000EF) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d d=%h, want lat=2 d=000000EF", lat, a_rsp_rdata);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 8'hFC; req_wdata = 32'hA5A5A5A5;
    a_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({a_rsp_valid, a_mem_stall} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_in_wait: got v=%b st=%b, want 0 0", a_rsp_valid, a_mem_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_release_ready: got %b, want 1", a_req_ready);
    end
    do_req(1'b0, 3'b010, 8'hFC, 32'd0, rd, er, lat);
    n_vec++;
    if (rd !== 32'hA5A5A5A5 || lat !== 2) begin
      n_err++;
      $display("FAIL store_survives_rst: got d=%h lat=%0d, want A5A5A5A5 lat=2", rd, lat);
    end
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'hFC;
    a_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    wait_a_valid(lat);
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({a_rsp_valid, a_rsp_err} !== 2'b00 || a_rsp_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL rst_in_resp: got v=%b e=%b d=%h, want 0 0 0", a_rsp_valid, a_rsp_err, a_rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_latency();
    test_load_ext();
    test_raw();
    test_backpressure();
    test_align();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
